// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction-fetch stage plus Fetch/Decode pipeline register for
//             the RV64I+Zba five-stage pipeline. Owns the PC, issues one
//             instruction-memory request at a time over a req/valid
//             handshake, absorbs stalls and execute-stage redirects, and
//             drives the FD register into decode.
//  Ports    : clk, rst (async, active-high)
//             StallF/StallD/FlushD     - hazard unit controls
//             PCSrc_E/PCTarget_E       - execute-stage redirect
//             imem_req/imem_addr       - fetch request (out)
//             imem_valid/imem_rdata    - fetch response (in)
//             PC_F, FetchStall_F       - fetch-side status
//             Instr_D/PC_D/PCPlus4_D/Valid_D - FD register
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrc_E,
  input  logic [63:0] PCTarget_E,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] PC_F,
  output logic        FetchStall_F,
  output logic [31:0] Instr_D,
  output logic [63:0] PC_D,
  output logic [63:0] PCPlus4_D,
  output logic        Valid_D
);

  // FETCH : request outstanding at r_pc
  // HOLD  : response captured while stalled, no request on the bus
  // DRAIN : stale request at r_drain_addr still outstanding after a redirect
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [63:0] r_pc;
  logic [63:0] w_pc_nxt;
  logic [63:0] r_drain_addr;
  logic        w_drain_ld;
  logic [31:0] r_hold_buf;
  logic        w_hold_ld;

  logic        w_avail;
  logic        w_deliver;
  logic [31:0] w_fd_instr;
  logic [63:0] w_pc_plus4;

  logic [31:0] r_instr_d;
  logic [63:0] r_pc_d;
  logic [63:0] r_pcplus4_d;
  logic        r_valid_d;

  assign w_pc_plus4 = r_pc + 64'd4;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and PC/buffer update decisions
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drain_ld  = 1'b0;
    w_hold_ld   = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (imem_valid) begin
          if (PCSrc_E) begin
            // Response belongs to the wrong path: drop it.
            w_pc_nxt = PCTarget_E;
          end else if (!StallF) begin
            w_pc_nxt = w_pc_plus4;
          end else begin
            w_hold_ld   = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end else if (PCSrc_E) begin
          // The bus request must stay stable until answered, so remember
          // the old address and swallow its response in DRAIN.
          w_drain_ld  = 1'b1;
          w_pc_nxt    = PCTarget_E;
          w_state_nxt = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (PCSrc_E) begin
          w_pc_nxt    = PCTarget_E;
          w_state_nxt = S_FETCH;
        end else if (!StallF) begin
          w_pc_nxt    = w_pc_plus4;
          w_state_nxt = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (PCSrc_E) begin
          w_pc_nxt = PCTarget_E;
        end
        if (imem_valid) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs derived from state
  // --------------------------------------------------------------------------
  always_comb begin
    imem_req     = 1'b0;
    imem_addr    = r_pc;
    w_avail      = 1'b0;
    w_fd_instr   = imem_rdata;
    case (r_state)
      S_FETCH: begin
        imem_req = !rst;
        w_avail  = imem_valid;
      end
      S_HOLD: begin
        w_avail    = 1'b1;
        w_fd_instr = r_hold_buf;
      end
      S_DRAIN: begin
        imem_req  = !rst;
        imem_addr = r_drain_addr;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
    FetchStall_F = !w_avail;
    w_deliver    = w_avail && !StallF && !PCSrc_E;
  end

  // --------------------------------------------------------------------------
  // PC, drain address and hold buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_hold_buf   <= NOP_INSTR;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_drain_ld) begin
        r_drain_addr <= r_pc;
      end
      if (w_hold_ld) begin
        r_hold_buf <= imem_rdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Fetch/Decode register: flush > stall > deliver > bubble
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_d   <= NOP_INSTR;
      r_pc_d      <= 64'd0;
      r_pcplus4_d <= 64'd0;
      r_valid_d   <= 1'b0;
    end else if (FlushD) begin
      r_instr_d   <= NOP_INSTR;
      r_pc_d      <= 64'd0;
      r_pcplus4_d <= 64'd0;
      r_valid_d   <= 1'b0;
    end else if (StallD) begin
      r_instr_d   <= r_instr_d;
      r_pc_d      <= r_pc_d;
      r_pcplus4_d <= r_pcplus4_d;
      r_valid_d   <= r_valid_d;
    end else if (w_deliver) begin
      // In HOLD the PC was frozen, so r_pc is still the buffered address.
      r_instr_d   <= w_fd_instr;
      r_pc_d      <= r_pc;
      r_pcplus4_d <= w_pc_plus4;
      r_valid_d   <= 1'b1;
    end else begin
      r_instr_d   <= NOP_INSTR;
      r_pc_d      <= 64'd0;
      r_pcplus4_d <= 64'd0;
      r_valid_d   <= 1'b0;
    end
  end

  assign PC_F      = r_pc;
  assign Instr_D   = r_instr_d;
  assign PC_D      = r_pc_d;
  assign PCPlus4_D = r_pcplus4_d;
  assign Valid_D   = r_valid_d;

endmodule
`default_nettype wire
